// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//   Read-side scanner for the pipeline register file. A start pulse makes the
//   block walk register indices FIRST_REG..LAST_REG through one combinational
//   read port. Each {index, data} pair is streamed out as a beat over a
//   valid/ready handshake. While a scan is in progress, hold_wb is raised so
//   the pipeline can stall writeback and the snapshot stays consistent.
//
// Ports
//   clk        in   1     clock, rising edge
//   clrn       in   1     asynchronous active-low reset
//   start      in   1     begin a scan (sampled only when idle)
//   abort      in   1     synchronous cancel of a scan in progress
//   rf_rn      out  RN_W  register-file read index
//   rf_q       in   DW    register-file read data for rf_rn (same cycle)
//   out_valid  out  1     beat available on out_idx/out_data
//   out_ready  in   1     consumer accepts the beat when out_valid & out_ready
//   out_idx    out  RN_W  register index of the current beat
//   out_data   out  DW    register value captured for out_idx
//   busy       out  1     scan or drain in progress
//   hold_wb    out  1     writeback stall request, same as busy
//   done       out  1     one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
   parameter int RN_W      = 5,
   parameter int DW        = 32,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            start,
   input  logic            abort,
   output logic [RN_W-1:0] rf_rn,
   input  logic [DW-1:0]   rf_q,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RN_W-1:0] out_idx,
   output logic [DW-1:0]   out_data,
   output logic            busy,
   output logic            hold_wb,
   output logic            done
);

   localparam logic [RN_W-1:0] FIRST_IDX = RN_W'(FIRST_REG);
   localparam logic [RN_W-1:0] LAST_IDX  = RN_W'(LAST_REG);

   // IDLE: waiting for start. SCAN: reading indices and filling the output
   // slot. DRAIN: last beat captured, waiting for it to be accepted.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state,    w_state_nxt;
   logic [RN_W-1:0]   r_idx,      w_idx_nxt;
   logic              r_valid,    w_valid_nxt;
   logic [RN_W-1:0]   r_out_idx,  w_out_idx_nxt;
   logic [DW-1:0]     r_out_data, w_out_data_nxt;
   logic              r_done,     w_done_nxt;
   logic [RN_W-1:0]   w_rf_rn;
   logic              w_slot_free;

   // The output slot can take a new beat when it is empty or when the beat
   // it holds is being accepted in this very cycle.
   assign w_slot_free = !r_valid || out_ready;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_valid_nxt    = r_valid;
      w_out_idx_nxt  = r_out_idx;
      w_out_data_nxt = r_out_data;
      w_done_nxt     = 1'b0;
      w_rf_rn        = '0;

      unique case (r_state)
         S_IDLE: begin
            // abort is a no-op here, so start always wins when both are high.
            if (start) begin
               w_state_nxt = S_SCAN;
               w_idx_nxt   = FIRST_IDX;
            end
         end

         S_SCAN: begin
            w_rf_rn = r_idx;
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
            end else if (w_slot_free) begin
               w_out_idx_nxt  = r_idx;
               w_out_data_nxt = rf_q;
               w_valid_nxt    = 1'b1;
               // idx stops at LAST_REG; it never increments past it.
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_idx_nxt = r_idx + RN_W'(1);
               end
            end
            // Slot busy: everything holds, so rf_rn and the payload are stable.
         end

         S_DRAIN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
            end else if (out_ready) begin
               // out_valid is 1 throughout DRAIN, so out_ready alone accepts.
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         // NOTE: the captured data word is a single register, not a memory
         // array, so clearing it on reset is cheap and makes all outputs 0.
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_valid    <= 1'b0;
         r_out_idx  <= '0;
         r_out_data <= '0;
         r_done     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_valid    <= w_valid_nxt;
         r_out_idx  <= w_out_idx_nxt;
         r_out_data <= w_out_data_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rf_rn     = w_rf_rn;
   assign out_valid = r_valid;
   assign out_idx   = r_out_idx;
   assign out_data  = r_out_data;
   assign busy      = (r_state != S_IDLE);
   assign hold_wb   = busy;
   assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
//   Directed bench for regfile_dump. One instance uses the default parameters
//   (full scan 1..31); a second instance uses FIRST_REG = LAST_REG = 5 for the
//   single-beat case. A small array stands in for the register file.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

   logic        clk = 1'b0;
   logic        clrn;
   logic        start, abort, out_ready;
   logic [4:0]  rf_rn, out_idx;
   logic [31:0] rf_q, out_data;
   logic        out_valid, busy, hold_wb, done;

   logic        start5, abort5, out_ready5;
   logic [4:0]  rf_rn5, out_idx5;
   logic [31:0] rf_q5, out_data5;
   logic        out_valid5, busy5, hold_wb5, done5;

   logic [31:0] rf [32];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   assign rf_q  = rf[rf_rn];
   assign rf_q5 = rf[rf_rn5];

   regfile_dump u_dut (
      .clk       (clk),
      .clrn      (clrn),
      .start     (start),
      .abort     (abort),
      .rf_rn     (rf_rn),
      .rf_q      (rf_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_data  (out_data),
      .busy      (busy),
      .hold_wb   (hold_wb),
      .done      (done)
   );

   regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut5 (
      .clk       (clk),
      .clrn      (clrn),
      .start     (start5),
      .abort     (abort5),
      .rf_rn     (rf_rn5),
      .rf_q      (rf_q5),
      .out_valid (out_valid5),
      .out_ready (out_ready5),
      .out_idx   (out_idx5),
      .out_data  (out_data5),
      .busy      (busy5),
      .hold_wb   (hold_wb5),
      .done      (done5)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rf_rn"},     rf_rn,     0);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " out_idx"},   out_idx,   0);
      check({tag, " out_data"},  out_data,  0);
      check({tag, " busy"},      busy,      0);
      check({tag, " hold_wb"},   hold_wb,   0);
      check({tag, " done"},      done,      0);
   endtask

   // Consume a scan already started. bp=1 alternates out_ready and holds it
   // low for 5 cycles at beat 7. restart_at pulses start when that beat is
   // accepted; abort_at raises abort while that beat is presented.
   task automatic consume(input int bp, input int restart_at, input int abort_at,
                          output int beats, output int dones);
      int    exp_idx;
      int    hold;
      bit    tog;
      bit    prev_stall;
      logic [4:0]  prev_idx, prev_rn;
      logic [31:0] prev_data;
      bit    finished;
      exp_idx = 1; hold = 0; tog = 1'b0; prev_stall = 1'b0;
      prev_idx = '0; prev_rn = '0; prev_data = '0;
      beats = 0; dones = 0; finished = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         start = 1'b0;
         abort = 1'b0;
         if (bp == 0) begin
            out_ready = 1'b1;
         end else if (out_valid && out_idx == 5'd7 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
         end else begin
            out_ready = tog;
            tog = ~tog;
         end
         if (prev_stall) begin
            check($sformatf("stall idx c%0d", cyc),  out_idx,  prev_idx);
            check($sformatf("stall data c%0d", cyc), out_data, prev_data);
            check($sformatf("stall rn c%0d", cyc),   rf_rn,    prev_rn);
         end
         if (done) begin
            dones++;
            check("done excl valid", out_valid, 0);
            check("beats before done", beats, 31);
            step();
            check("done one cycle", done, 0);
            finished = 1'b1;
         end else if (abort_at >= 0 && out_valid && out_idx == 5'(abort_at)) begin
            abort = 1'b1;
            out_ready = 1'b0;
            step();
            abort = 1'b0;
            check("abort valid", out_valid, 0);
            check("abort busy",  busy,      0);
            check("abort done",  done,      0);
            step();
            check("abort no done", done, 0);
            check("abort rf_rn",   rf_rn, 0);
            finished = 1'b1;
         end else begin
            if (out_valid && out_ready) begin
               check($sformatf("beat idx #%0d", beats),  out_idx,  exp_idx);
               check($sformatf("beat data #%0d", beats), out_data, rf[exp_idx]);
               beats++;
               exp_idx++;
               if (out_idx == 5'(restart_at)) start = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_data  = out_data;
            prev_rn    = rf_rn;
            step();
         end
      end
      if (!finished) check("consume timeout", 1, 0);
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, dones;

      // ---------------- 1: reset ----------------
      clrn = 1'b0;
      start5 = 1'b0; abort5 = 1'b0; out_ready5 = 1'b0;
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom); abort = 1'($urandom); out_ready = 1'($urandom);
         step();
         check_all_zero($sformatf("reset%0d", i));
      end
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      clrn = 1'b1;
      step(); step();
      check_all_zero("post-reset idle");

      // ---------------- 2: full scan, cycle exact ----------------
      for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + k;
      rf[0] = 32'h0;
      start = 1'b1;
      out_ready = 1'b1;
      check("c0 busy", busy, 0);
      step();
      start = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         check($sformatf("c%0d busy", c),      busy,      (c >= 1 && c <= 32));
         check($sformatf("c%0d hold_wb", c),   hold_wb,   (c >= 1 && c <= 32));
         check($sformatf("c%0d out_valid", c), out_valid, (c >= 2 && c <= 32));
         check($sformatf("c%0d done", c),      done,      (c == 33));
         if (c >= 2 && c <= 32) begin
            check($sformatf("c%0d out_idx", c),  out_idx,  c - 1);
            check($sformatf("c%0d out_data", c), out_data, 32'h1000_0000 + c - 1);
         end
         if (c <= 31) check($sformatf("c%0d rf_rn", c), rf_rn, c);
         step();
      end

      // ---------------- 3: backpressure ----------------
      start = 1'b1;
      step();
      consume(1, -1, -1, beats, dones);
      check("bp beats", beats, 31);
      check("bp dones", dones, 1);

      // ---------------- 4: control ----------------
      start = 1'b1;
      step();
      consume(0, 4, -1, beats, dones);
      check("restart ignored beats", beats, 31);
      check("restart ignored dones", dones, 1);
      check("restart ignored idle", busy, 0);

      start = 1'b1;
      step();
      consume(0, -1, 10, beats, dones);
      check("abort beats", beats, 9);

      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort idle busy",  busy,      0);
      check("abort idle valid", out_valid, 0);

      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start beats abort busy", busy,  1);
      check("rescan rf_rn",           rf_rn, 1);
      consume(0, -1, -1, beats, dones);
      check("rescan beats", beats, 31);
      check("rescan dones", dones, 1);

      // ---------------- 5: reset mid-scan ----------------
      start = 1'b1;
      out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40 && !(out_valid && out_idx == 5'd15); i++) step();
      check("mid-scan reached beat 15", out_idx, 15);
      #2;
      clrn = 1'b0;
      #1;
      check_all_zero("async reset");
      step();
      clrn = 1'b1;
      step();
      check_all_zero("after mid reset");
      start = 1'b1;
      step();
      consume(0, -1, -1, beats, dones);
      check("post-reset scan beats", beats, 31);
      check("post-reset scan dones", dones, 1);

      // ---------------- 6: FIRST_REG = LAST_REG = 5 ----------------
      rf[5] = 32'hDEAD_BEEF;
      start5 = 1'b1;
      out_ready5 = 1'b0;
      step();
      start5 = 1'b0;
      check("p5 c1 busy",  busy5,      1);
      check("p5 c1 rf_rn", rf_rn5,     5);
      check("p5 c1 valid", out_valid5, 0);
      step();
      check("p5 c2 valid", out_valid5, 1);
      check("p5 c2 idx",   out_idx5,   5);
      check("p5 c2 data",  out_data5,  32'hDEAD_BEEF);
      check("p5 c2 rf_rn", rf_rn5,     0);
      step();
      check("p5 c3 valid held", out_valid5, 1);
      check("p5 c3 data held",  out_data5,  32'hDEAD_BEEF);
      check("p5 c3 done",       done5,      0);
      out_ready5 = 1'b1;
      step();
      out_ready5 = 1'b0;
      check("p5 c4 done",  done5,      1);
      check("p5 c4 valid", out_valid5, 0);
      check("p5 c4 busy",  busy5,      0);
      step();
      check("p5 c5 done",  done5,      0);
      check("p5 c5 valid", out_valid5, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
